// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the MNIST CNN pipeline.
// relu_sat is used by both pooling stages.
package cnn_pkg;

  localparam int CONV2_OUT_W = 8;
  localparam int CONV2_OUT_H = 8;
  localparam int CONV2_DW    = 14;
  localparam int POOL2_DW    = 12;

  typedef struct packed {
    logic load_h;
    logic wr_lb;
    logic emit;
  } lane_ctl_t;

  function automatic logic signed [31:0] relu_sat(
    input logic signed [31:0] x,
    input int                 dw_out
  );
    logic signed [31:0] lim;
    lim = (32'sd1 <<< (dw_out - 1)) - 32'sd1;
    if (x < 0) return 32'sd0;
    if (x > lim) return lim;
    return x;
  endfunction

endpackage

// File: rtl/maxpool_lane.sv
// One channel of the 2x2 max pool: ReLU/saturate, horizontal pair,
// line buffer of pair maxima and the registered pooled output.
module maxpool_lane
  import cnn_pkg::*;
#(
  parameter int IN_W   = CONV2_OUT_W,
  parameter int DW_IN  = CONV2_DW,
  parameter int DW_OUT = POOL2_DW,
  parameter int LBW    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  lane_ctl_t                ctl,
  input  logic [LBW-1:0]           lb_idx,
  input  logic signed [DW_IN-1:0]  x,
  output logic signed [DW_OUT-1:0] y
);

  localparam int NLB = IN_W / 2;

  logic signed [DW_OUT-1:0] r;
  logic signed [DW_OUT-1:0] hmax;
  logic signed [DW_OUT-1:0] pmax;
  logic signed [DW_OUT-1:0] lb_rd;
  logic signed [DW_OUT-1:0] h_d;
  logic signed [DW_OUT-1:0] h_q;
  logic signed [DW_OUT-1:0] pool_d;
  logic signed [DW_OUT-1:0] pool_q;
  logic signed [DW_OUT-1:0] lb_q [NLB];

  always_comb begin
    r      = DW_OUT'(relu_sat(32'(x), DW_OUT));
    lb_rd  = lb_q[lb_idx];
    hmax   = (r > h_q) ? r : h_q;
    pmax   = (lb_rd > hmax) ? lb_rd : hmax;
    h_d    = ctl.load_h ? r : h_q;
    pool_d = ctl.emit ? pmax : pool_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q    <= '0;
      pool_q <= '0;
    end else begin
      h_q    <= h_d;
      pool_q <= pool_d;
    end
  end

  // Rewritten on every even row, so it never needs clearing.
  always_ff @(posedge clk) begin
    if (!rst && ctl.wr_lb) begin
      lb_q[lb_idx] <= hmax;
    end
  end

  assign y = pool_q;

endmodule

// File: rtl/maxpool_relu_2.sv
// Second ReLU + 2x2/stride-2 max pool over three conv2 channels.
// Owns the raster counters and the output handshake flags.
module maxpool_relu_2
  import cnn_pkg::*;
#(
  parameter int IN_W   = CONV2_OUT_W,
  parameter int IN_H   = CONV2_OUT_H,
  parameter int DW_IN  = CONV2_DW,
  parameter int DW_OUT = POOL2_DW,
  localparam int OIW   = $clog2(IN_W * IN_H / 4)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic signed [DW_IN-1:0]  conv_in_1,
  input  logic signed [DW_IN-1:0]  conv_in_2,
  input  logic signed [DW_IN-1:0]  conv_in_3,
  output logic signed [DW_OUT-1:0] pool_out_1,
  output logic signed [DW_OUT-1:0] pool_out_2,
  output logic signed [DW_OUT-1:0] pool_out_3,
  output logic                     valid_out,
  output logic [OIW-1:0]           out_idx,
  output logic                     frame_done
);

  localparam int CW  = $clog2(IN_W);
  localparam int RW  = $clog2(IN_H);
  localparam int LBW = (IN_W > 2) ? $clog2(IN_W / 2) : 1;

  logic [CW-1:0]  col_d;
  logic [CW-1:0]  col_q;
  logic [RW-1:0]  row_d;
  logic [RW-1:0]  row_q;
  logic           col_last;
  logic           row_last;
  lane_ctl_t      ctl;
  logic [LBW-1:0] lb_idx;
  logic           valid_out_d;
  logic           valid_out_q;
  logic           frame_done_d;
  logic           frame_done_q;
  logic [OIW-1:0] out_idx_d;
  logic [OIW-1:0] out_idx_q;

  always_comb begin
    col_last   = (col_q == CW'(IN_W - 1));
    row_last   = (row_q == RW'(IN_H - 1));
    ctl        = '0;
    ctl.load_h = valid_in & ~col_q[0];
    ctl.wr_lb  = valid_in & col_q[0] & ~row_q[0];
    ctl.emit   = valid_in & col_q[0] & row_q[0];
    lb_idx     = LBW'(col_q >> 1);

    col_d = col_q;
    row_d = row_q;
    if (valid_in) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    valid_out_d  = ctl.emit;
    frame_done_d = ctl.emit & col_last & row_last;
    out_idx_d    = out_idx_q;
    if (ctl.emit) begin
      out_idx_d = OIW'(int'(row_q >> 1) * (IN_W / 2)
                       + int'(col_q >> 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_idx_q    <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
      out_idx_q    <= out_idx_d;
    end
  end

  maxpool_lane #(
    .IN_W  (IN_W),
    .DW_IN (DW_IN),
    .DW_OUT(DW_OUT),
    .LBW   (LBW)
  ) u_lane_1 (
    .clk   (clk),
    .rst   (rst),
    .ctl   (ctl),
    .lb_idx(lb_idx),
    .x     (conv_in_1),
    .y     (pool_out_1)
  );

  maxpool_lane #(
    .IN_W  (IN_W),
    .DW_IN (DW_IN),
    .DW_OUT(DW_OUT),
    .LBW   (LBW)
  ) u_lane_2 (
    .clk   (clk),
    .rst   (rst),
    .ctl   (ctl),
    .lb_idx(lb_idx),
    .x     (conv_in_2),
    .y     (pool_out_2)
  );

  maxpool_lane #(
    .IN_W  (IN_W),
    .DW_IN (DW_IN),
    .DW_OUT(DW_OUT),
    .LBW   (LBW)
  ) u_lane_3 (
    .clk   (clk),
    .rst   (rst),
    .ctl   (ctl),
    .lb_idx(lb_idx),
    .x     (conv_in_3),
    .y     (pool_out_3)
  );

  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;
  assign out_idx    = out_idx_q;

endmodule

// File: tb/tb_maxpool_relu_2.sv
// Directed bench for maxpool_relu_2: table of expected pooled
// values per frame pattern, plus reset and back-to-back sequences.
module tb_maxpool_relu_2;

  logic               clk = 1'b0;
  logic               rst;
  logic               valid_in;
  logic signed [13:0] conv_in_1;
  logic signed [13:0] conv_in_2;
  logic signed [13:0] conv_in_3;
  logic signed [11:0] pool_out_1;
  logic signed [11:0] pool_out_2;
  logic signed [11:0] pool_out_3;
  logic               valid_out;
  logic [3:0]         out_idx;
  logic               frame_done;

  maxpool_relu_2 dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .conv_in_1 (conv_in_1),
    .conv_in_2 (conv_in_2),
    .conv_in_3 (conv_in_3),
    .pool_out_1(pool_out_1),
    .pool_out_2(pool_out_2),
    .pool_out_3(pool_out_3),
    .valid_out (valid_out),
    .out_idx   (out_idx),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    int pat;
    int idx;
    int e1;
    int e2;
    int e3;
  } vec_t;

  vec_t tbl [32];

  int q_idx [$];
  int q_v1  [$];
  int q_v2  [$];
  int q_v3  [$];
  int q_fd  [$];
  int q_cyc [$];
  int q_exp [$];

  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      q_idx.push_back(int'(out_idx));
      q_v1.push_back(int'(pool_out_1));
      q_v2.push_back(int'(pool_out_2));
      q_v3.push_back(int'(pool_out_3));
      q_fd.push_back(int'(frame_done));
      q_cyc.push_back(cyc);
    end
  end

  function automatic int sample(int pat, int ch, int r, int c);
    if (pat == 0) begin
      if (ch == 1) return r * 8 + c;
      if (ch == 2) begin
        if (r == 1 && c == 1) return 100;
        if (r == 7 && c == 7) return -1;
        return -5;
      end
      if (r == 0 && c == 0) return 8191;
      if (r == 2 && c == 2) return -8192;
      if (r >= 4 && r <= 5 && c >= 4 && c <= 5) return 7;
      if (r == 6 && c == 0) return 2048;
      if (r == 6 && c == 6) return 2046;
      return 0;
    end
    if (ch == 1) return -(r * 8 + c);
    if (ch == 2) return -8192;
    return 8191;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic clear_q();
    q_idx.delete();
    q_v1.delete();
    q_v2.delete();
    q_v3.delete();
    q_fd.delete();
    q_cyc.delete();
    q_exp.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
  endtask

  task automatic send_frame(input int pat, input int gap, input int nsamp);
    int n;
    n = 0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (n < nsamp) begin
          @(negedge clk);
          valid_in  = 1'b1;
          conv_in_1 = 14'(sample(pat, 1, r, c));
          conv_in_2 = 14'(sample(pat, 2, r, c));
          conv_in_3 = 14'(sample(pat, 3, r, c));
          if (r % 2 == 1 && c % 2 == 1) q_exp.push_back(cyc + 1);
          n++;
          for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            valid_in  = 1'b0;
            conv_in_1 = 14'($urandom);
            conv_in_2 = 14'($urandom);
            conv_in_3 = 14'($urandom);
          end
        end
      end
    end
  endtask

  task automatic check_frame(input int pat, input int base);
    int j;
    foreach (tbl[i]) begin
      if (tbl[i].pat == pat) begin
        j = base + tbl[i].idx;
        if (j >= q_v1.size() || j >= q_exp.size()) begin
          chk("missing output", q_v1.size(), j + 1);
        end else begin
          chk("out_idx", q_idx[j], tbl[i].idx);
          chk("pool_out_1", q_v1[j], tbl[i].e1);
          chk("pool_out_2", q_v2[j], tbl[i].e2);
          chk("pool_out_3", q_v3[j], tbl[i].e3);
          chk("frame_done", q_fd[j], (tbl[i].idx == 15) ? 1 : 0);
          chk("latency cycle", q_cyc[j], q_exp[j]);
        end
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " valid_out"}, int'(valid_out), 0);
    chk({tag, " out_idx"}, int'(out_idx), 0);
    chk({tag, " frame_done"}, int'(frame_done), 0);
    chk({tag, " pool_out_1"}, int'(pool_out_1), 0);
    chk({tag, " pool_out_2"}, int'(pool_out_2), 0);
    chk({tag, " pool_out_3"}, int'(pool_out_3), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 16; k++) begin
      tbl[k]      = '{0, k, 16 * (k / 4) + 9 + 2 * (k % 4), 0, 0};
      tbl[16 + k] = '{1, k, 0, 0, 2047};
    end
    tbl[0].e2  = 100;
    tbl[0].e3  = 2047;
    tbl[5].e3  = 0;
    tbl[10].e3 = 7;
    tbl[12].e3 = 2047;
    tbl[15].e3 = 2046;

    rst       = 1'b1;
    valid_in  = 1'b1;
    conv_in_1 = 14'sd100;
    conv_in_2 = 14'sd100;
    conv_in_3 = 14'sd100;
    repeat (3) @(negedge clk);
    check_reset_state("init");
    rst      = 1'b0;
    valid_in = 1'b0;
    clear_q();

    send_frame(0, 0, 64);
    send_frame(1, 0, 64);
    idle(4);
    chk("b2b output count", q_v1.size(), 32);
    check_frame(0, 0);
    check_frame(1, 16);

    clear_q();
    send_frame(0, 1, 64);
    idle(4);
    chk("alt output count", q_v1.size(), 16);
    check_frame(0, 0);

    clear_q();
    send_frame(0, 0, 37);
    @(negedge clk);
    rst       = 1'b1;
    valid_in  = 1'b1;
    conv_in_1 = 14'sd999;
    conv_in_2 = 14'sd999;
    conv_in_3 = 14'sd999;
    @(negedge clk);
    check_reset_state("midrst");
    rst      = 1'b0;
    valid_in = 1'b0;
    clear_q();
    idle(2);
    send_frame(0, 0, 64);
    idle(4);
    chk("post-reset output count", q_v1.size(), 16);
    check_frame(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/maxpool_relu_2.md
# maxpool_relu_2

Second pooling stage of the MNIST CNN. It sits directly downstream of the three conv2 channel calculators and consumes their 14-bit convolution sums as an 8×8 raster per channel. It applies ReLU, saturates the result, and performs 2×2 / stride-2 max pooling per channel. It emits 16 pooled 12-bit values per channel per image to the fully-connected stage.

## Interface
Parameters:
- `IN_W`, default 8: feature-map width (columns) per channel; must be even.
- `IN_H`, default 8: feature-map height (rows); must be even.
- `DW_IN`, default 14: signed input sample width.
- `DW_OUT`, default 12: signed output width; output is always ≥ 0.

Ports (one clock; reset is synchronous and active-high):
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: synchronous active-high reset.
- `valid_in`, input, 1: one raster sample present on all three channels this cycle.
- `conv_in_1`, `conv_in_2`, `conv_in_3`, input, `DW_IN` each, signed: conv2 channel sums (`conv_out_calc` of each calculator).
- `pool_out_1`, `pool_out_2`, `pool_out_3`, output, `DW_OUT` each, signed: pooled results.
- `valid_out`, output, 1: single-cycle pulse; `pool_out_*` valid.
- `out_idx`, output, 4 (log2(IN_W·IN_H/4)): raster index of the pooled pixel, 0..15.
- `frame_done`, output, 1: pulses together with the last `valid_out` of a frame.

## Operation
- **Counters.** `col` runs 0..IN_W-1 and `row` runs 0..IN_H-1.
  - Both advance only on `valid_in`; `col` wraps to 0 and increments `row`.
  - `row` wraps to 0 after `IN_H-1`.
- **ReLU and saturation, per sample and per channel.**
  - `r = (x < 0) ? 0 : x`.
  - If `r > 2^(DW_OUT-1)-1`, then `r = 2^(DW_OUT-1)-1` (2047).
  - All compares are signed.
- **Even row.**
  - Even `col`: store `r` in horizontal register `h`.
  - Odd `col`: write `max(h, r)` to `linebuf[col/2]`. There are `IN_W/2` entries per channel.
- **Odd row.**
  - Even `col`: store `r` in `h`.
  - Odd `col`: result = `max(h, r, linebuf[col/2])`. Register it to `pool_out_*` and assert `valid_out`.
  - `out_idx` = `(row/2)·(IN_W/2) + col/2`.
- **Frame end.** `frame_done` = `valid_out` at `row = IN_H-1`, `col = IN_W-1`. Counters are at (0,0) on the next cycle, ready for the next frame with no gap.
- **Stalls.** `valid_in` gaps of any length are allowed. Internal state holds and `valid_out` stays low. The upstream calculator asserts valid on alternate cycles; both that pattern and a continuous `valid_in` are supported.
- **Ties.** Equal values select either operand; the result is identical.
- **Overwrite.** `linebuf` is overwritten every even row, so stale contents never reach the output.

## Timing
- **Reset values.** On `rst` at a clock edge:
  - `col`, `row`, `h` ← 0.
  - `pool_out_*` ← 0, `valid_out` ← 0, `out_idx` ← 0, `frame_done` ← 0.
  - `linebuf` is not reset.
- **Reset mid-frame.** The partial frame is discarded and no output is produced for it. The next `valid_in` is treated as pixel (0,0).
- **`valid_in` during reset** is ignored.
- **Latency.** `valid_out` is asserted on the cycle after the edge that samples the `valid_in` for pixel (odd row, odd col). That is one register stage.
- **Combinational path.** Max-of-3 plus ReLU/saturation is combinational between the input and the output register.
- **Throughput.** One sample per cycle per channel. At most one `valid_out` per two `valid_in`.
- **No backpressure.** The consumer must accept every `valid_out` pulse.

## Structure
- **Shared package `cnn_pkg`.**
  - `CONV2_OUT_W` = 8, `CONV2_OUT_H` = 8, `CONV2_DW` = 14, `POOL2_DW` = 12.
  - `relu_sat` function shared with the pool1 stage.
- **Sub-module `maxpool_lane`.** One channel, instantiated three times. Contains `h`, `linebuf`, the ReLU/saturate logic, the max-of-3 and the output register. It takes `col`/`row` phase strobes from the parent.
- **Parent `maxpool_relu_2`.** Owns the counters, `valid_out`, `out_idx` and `frame_done`.

## Test plan
- **Ramp frame.** Channel 1 sample = `row*8+col`, `valid_in` continuous → 16 pulses. Expected values:
  - `pool_out_1` = 9, 11, 13, 15, 25, …, 63.
  - `out_idx` = 0..15.
  - `frame_done` only with value 63.
- **ReLU.** All samples −5 on channel 2, except pixel (1,1) = 100 → `pool_out_2` = 100 at idx 0 and 0 at every other idx.
- **Saturation.** Pixel (0,0) = 8191 on channel 3 and all others 0 → idx 0 value 2047.
- **Alternating `valid_in`.** Same ramp with one-cycle gaps, matching the conv2 calculator's alternate-cycle valid pattern → identical results. Each `valid_out` appears exactly one cycle after the qualifying sample.
- **Reset mid-frame.** Assert `rst` after 37 samples, then send a full ramp frame → no output from the partial frame, and the new frame's results match the ramp expectation exactly.
- **Back-to-back frames.** Two frames with no gap, the second negated ramp → frame 2 outputs all 0. There are two `frame_done` pulses, 16 outputs apart.
